// File: rtl/rr_req_arbiter.sv
// ============================================================================
// rr_req_arbiter : round-robin arbiter with hold-limit timeout and 1-cycle gap
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_req_arbiter #(
  parameter int NREQ     = 8,
  parameter int MAX_HOLD = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] done,
  output logic [NREQ-1:0] grant,
  output logic [2:0]      grant_id,
  output logic            busy,
  output logic            timeout
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0]      HOLD_LAST = 4'(MAX_HOLD - 1);
  localparam logic [3:0]      NREQ_W    = 4'(NREQ);
  localparam logic [2:0]      LAST_ID   = 3'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0  = {{(NREQ-1){1'b0}}, 1'b1};

  state_t          state, state_nxt;
  logic [2:0]      ptr, ptr_nxt;
  logic [3:0]      hcnt, hcnt_nxt;
  logic [NREQ-1:0] grant_nxt;
  logic [2:0]      gid_nxt;

  logic            found;
  logic [2:0]      sel_id;
  logic [3:0]      idx;
  logic            rel;
  logic            hold_exp;

  // Rotating priority search starting at ptr, wrapping modulo NREQ
  always_comb begin
    found  = 1'b0;
    sel_id = 3'd0;
    idx    = 4'd0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr} + 4'(i);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (!found && req[idx[2:0]]) begin
        found  = 1'b1;
        sel_id = idx[2:0];
      end
    end
  end

  // Only the owner's done/req bits can end a grant
  assign rel      = |(grant & (done | ~req));
  assign hold_exp = (hcnt == HOLD_LAST);
  assign timeout  = (state == GRANT) && !rel && hold_exp && !rst;
  assign busy     = |grant;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    hcnt_nxt  = hcnt;
    grant_nxt = grant;
    gid_nxt   = grant_id;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GRANT;
          grant_nxt = ONE_HOT0 << sel_id;
          gid_nxt   = sel_id;
          hcnt_nxt  = 4'd0;
        end
      end
      GRANT: begin
        if (rel || hold_exp) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          hcnt_nxt  = 4'd0;
          ptr_nxt   = (grant_id == LAST_ID) ? 3'd0 : 3'(grant_id + 3'd1);
        end else begin
          hcnt_nxt  = 4'(hcnt + 4'd1);
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 3'd0;
      hcnt     <= 4'd0;
      grant    <= '0;
      grant_id <= 3'd0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hcnt     <= hcnt_nxt;
      grant    <= grant_nxt;
      grant_id <= gid_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_req_arbiter.sv
// ============================================================================
// tb_rr_req_arbiter : directed self-checking bench, NREQ=8, MAX_HOLD=4
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rr_req_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] done;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       busy;
  logic       timeout;

  int checks;
  int errors;

  rr_req_arbiter #(.NREQ(8), .MAX_HOLD(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] g, input logic [2:0] id,
                         input logic b, input logic t);
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    if (b) chk({tag, "_id"}, 32'(grant_id), 32'(id));
    chk({tag, "_busy"}, 32'(busy), 32'(b));
    chk({tag, "_timeout"}, 32'(timeout), 32'(t));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst  = 1'b1;
    req  = 8'h00;
    done = 8'h00;
    step();
    step();
    chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    chk("reset_gid", 32'(grant_id), 32'd0);

    // First grant after reset, searched from ptr=0
    rst = 1'b0;
    req = 8'h81;
    step();
    chk_out("first", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h00;
    step();
    chk_out("withdraw0", 8'h00, 3'd0, 1'b0, 1'b0);

    // Fairness: 0..7 then 0 again, each followed by one idle cycle
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      step();
      chk_out($sformatf("rr%0d", k), 8'h01 << (k % 8), 3'(k % 8), 1'b1, 1'b0);
      done = 8'hFF;
      step();
      chk_out($sformatf("rr%0d_gap", k), 8'h00, 3'd0, 1'b0, 1'b0);
      done = 8'h00;
    end
    req = 8'h00;
    step();

    // Timeout: requester 3 holds for MAX_HOLD cycles
    req = 8'h08;
    step();
    chk_out("to_c0", 8'h08, 3'd3, 1'b1, 1'b0);
    step();
    step();
    chk_out("to_c2", 8'h08, 3'd3, 1'b1, 1'b0);
    step();
    chk_out("to_c3", 8'h08, 3'd3, 1'b1, 1'b1);
    step();
    chk_out("to_rel", 8'h00, 3'd0, 1'b0, 1'b0);
    // ptr should now be 4: with bits 0,3,4 requesting, 4 wins
    req = 8'h19;
    step();
    chk_out("to_ptr", 8'h10, 3'd4, 1'b1, 1'b0);
    req = 8'h00;
    step();

    // Coincidence: done on the last hold cycle is a normal release (ptr=5 wraps to 3)
    req = 8'h08;
    step();
    chk_out("co_c0", 8'h08, 3'd3, 1'b1, 1'b0);
    step();
    step();
    step();
    done = 8'h08;
    #1;
    chk_out("co_c3", 8'h08, 3'd3, 1'b1, 1'b0);
    step();
    chk_out("co_rel", 8'h00, 3'd0, 1'b0, 1'b0);
    done = 8'h00;
    req  = 8'h00;

    // Wrap: move ptr to 7, then only req[0]
    req = 8'h40;
    step();
    chk_out("wr_g6", 8'h40, 3'd6, 1'b1, 1'b0);
    req = 8'h00;
    step();
    req = 8'h01;
    step();
    chk_out("wr_g0", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h00;
    step();
    chk_out("wr_rel", 8'h00, 3'd0, 1'b0, 1'b0);
    req = 8'h03;
    step();
    chk_out("wr_ptr1", 8'h02, 3'd1, 1'b1, 1'b0);
    req = 8'h00;
    step();

    // Reset mid-grant
    req = 8'h20;
    step();
    chk_out("rs_g5", 8'h20, 3'd5, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    chk_out("rs_drop", 8'h00, 3'd0, 1'b0, 1'b0);
    chk("rs_gid", 32'(grant_id), 32'd0);
    rst = 1'b0;
    req = 8'h21;
    step();
    chk_out("rs_resume", 8'h01, 3'd0, 1'b1, 1'b0);

    // Non-owner done bits are ignored; owner done releases
    done = 8'hFE;
    step();
    chk_out("np_hold", 8'h01, 3'd0, 1'b1, 1'b0);
    done = 8'h01;
    step();
    chk_out("np_rel", 8'h00, 3'd0, 1'b0, 1'b0);
    done = 8'h00;
    step();
    chk_out("np_next", 8'h20, 3'd5, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rr_req_arbiter.md
RR_REQ_ARBITER -- requirements
Module: rr_req_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 8: number of requesters; legal range 2..8.
REQ-002 The block SHALL have parameter MAX_HOLD, default 15: maximum consecutive grant cycles; legal range 2..15.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port req  input  NREQ  level request, one bit per requester.
REQ-006 The block SHALL have port done  input  NREQ  release strobe, one bit per requester; sampled only for the granted requester.
REQ-007 The block SHALL have port grant  output  NREQ  one-hot grant, registered; all-zero when no owner.
REQ-008 The block SHALL have port grant_id  output  3  index of current owner; valid only while busy=1.
REQ-009 The block SHALL have port busy  output  1  high while any grant bit is high.
REQ-010 The block SHALL have port timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-011 The block SHALL implement a two-state FSM, IDLE and GRANT; it SHALL hold a round-robin pointer ptr (0..NREQ-1) and a 4-bit hold counter hcnt.
REQ-012 In IDLE with req nonzero, the block SHALL select the first set req bit at index ptr, ptr+1, ... wrapping modulo NREQ, and SHALL enter GRANT with that one-hot grant on the next edge (req-to-grant latency 1 cycle).
REQ-013 In IDLE with req all-zero, the block SHALL remain in IDLE with grant=0, and ptr SHALL be unchanged.
REQ-014 On entry to GRANT, hcnt SHALL be 0; each cycle spent in GRANT without release SHALL increment hcnt by 1.
REQ-015 In GRANT with owner g, release SHALL occur when done[g]=1 or req[g]=0; on the next edge, grant SHALL go to 0, the FSM SHALL return to IDLE, and ptr SHALL become (g+1) mod NREQ.
REQ-016 In GRANT, if hcnt=MAX_HOLD-1 and no release condition is present, timeout SHALL be 1 that cycle and the FSM SHALL revoke exactly as in REQ-015; grant is therefore high for at most MAX_HOLD cycles.
REQ-017 If done[g]=1 coincides with hcnt=MAX_HOLD-1, the release SHALL be a normal release and timeout SHALL stay 0.
REQ-018 done or req changes on non-granted bits during GRANT SHALL have no effect; there SHALL be no preemption.
REQ-019 Every release SHALL be followed by exactly one IDLE cycle with grant=0 before the next grant (minimum gap 1 cycle).
REQ-020 grant SHALL never have more than one bit set; grant_id SHALL equal the index of the set bit; busy SHALL equal OR(grant).
REQ-021 Wrap-around: with ptr=NREQ-1 and only req[0] set, the grant SHALL go to requester 0.
REQ-022 req bits at index >= NREQ SHALL not exist; grant_id SHALL be zero-extended to 3 bits.

Reset
REQ-023 While rst=1 at a clock edge, the block SHALL set: FSM=IDLE, ptr=0, hcnt=0, grant=0, grant_id=0, busy=0, timeout=0.
REQ-024 An asserted rst in GRANT SHALL drop grant on that edge with no timeout pulse, regardless of req and done.
REQ-025 After rst deasserts, arbitration SHALL resume in the first cycle, and the reset-time req SHALL be evaluated from ptr=0.

Verification (NREQ=8, MAX_HOLD=4 unless stated)
REQ-026 After reset, req=8'b1000_0001 -> next cycle grant=8'h01, grant_id=0, busy=1.
REQ-027 Fairness: req=8'hFF held continuously, each owner asserts done one cycle after its grant -> grant order 0,1,2,...,7,0, with one idle cycle between grants.
REQ-028 Timeout: req[3]=1 held, done=0 -> grant[3] high 4 cycles, timeout=1 on the 4th cycle, grant=0 next cycle, ptr=4.
REQ-029 Coincidence: done[3]=1 on the cycle where hcnt=3 -> timeout stays 0, normal release.
REQ-030 Wrap and withdraw: ptr=7, req=8'h01 -> grant=8'h01; then req[0] deasserts -> grant=0 next cycle, ptr=1.
REQ-031 Reset mid-grant: grant=8'h20, assert rst one cycle -> grant=0 and busy=0 at that edge, timeout=0; after release with req=8'h21 -> grant=8'h01.
